// File: rtl/jt1942_rom_pkg.sv
// Shared constants and types for the 1942 ROM scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jt1942_rom_pkg;
    localparam int NCLI     = 5;
    localparam int CLI_CHAR = 0;
    localparam int CLI_SCR  = 1;
    localparam int CLI_OBJ  = 2;
    localparam int CLI_MAIN = 3;
    localparam int CLI_SND  = 4;

    // Widest cache tag (main CPU: 17-bit byte address -> 16-bit word index)
    localparam int TAG_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    // Round-robin successor of a client index
    function automatic logic [2:0] next_cli(input logic [2:0] c);
        return (c == 3'(NCLI - 1)) ? 3'd0 : c + 3'd1;
    endfunction
endpackage

// File: rtl/jt1942_rom_line.sv
// One-word line cache for a byte-wide ROM client: tag compare, byte select, fill, invalidate.
// Latency: hit reported combinationally; a fill is visible the cycle after the fill strobe.
// Backpressure: none; the client simply sees ok low until the scheduler fills the line.
module jt1942_rom_line #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic          inval,
    input  logic          fill,
    input  logic [AW-2:0] fill_tag,
    input  logic [15:0]   fill_word,
    output logic          ok,
    output logic [7:0]    data
);
    logic          valid;
    logic [AW-2:0] tag;
    logic [15:0]   word;

    // Line state: invalidation wins over a fill so a download never leaves stale data marked valid
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else begin
            if (fill) begin
                tag  <= fill_tag;
                word <= fill_word;
            end
            if (inval) begin
                valid <= 1'b0;
            end else if (fill) begin
                valid <= 1'b1;
            end
        end
    end

    assign ok   = cs && valid && (tag == addr[AW-1:1]);
    assign data = addr[0] ? word[15:8] : word[7:0];
endmodule

// File: rtl/jt1942_rom_sched.sv
// Round-robin scheduler sharing one 16-bit SDRAM read port among five cached byte-wide ROM clients.
// Latency: hits in the same cycle; a miss raises sdram_req one cycle later, ok follows data_rdy by one cycle.
// Backpressure: sdram_req held until sdram_ack; clients wait on ok (main CPU uses it as wait_n).
module jt1942_rom_sched
    import jt1942_rom_pkg::*;
#(
    parameter logic [21:0] CHAR_OFF = 22'h0,
    parameter logic [21:0] SCR_OFF  = 22'h0,
    parameter logic [21:0] OBJ_OFF  = 22'h0,
    parameter logic [21:0] MAIN_OFF = 22'h0,
    parameter logic [21:0] SND_OFF  = 22'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [12:0] char_addr,
    input  logic [14:0] scr_addr,
    input  logic [14:0] obj_addr,
    input  logic [16:0] main_addr,
    input  logic [14:0] snd_addr,
    input  logic        char_cs,
    input  logic        scr_cs,
    input  logic        obj_cs,
    input  logic        main_cs,
    input  logic        snd_cs,
    output logic        char_ok,
    output logic        scr_ok,
    output logic        obj_ok,
    output logic        main_ok,
    output logic        snd_ok,
    output logic [7:0]  char_data,
    output logic [7:0]  scr_data,
    output logic [7:0]  obj_data,
    output logic [7:0]  main_data,
    output logic [7:0]  snd_data,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [15:0] sdram_dout
);
    state_t            st, st_nxt;
    logic [2:0]        ptr, gnt, pick;
    logic              found, grant, fill_any;
    logic [TAG_W-1:0]  lat_addr;
    logic [NCLI-1:0]   cs_v, ok_v, pend, fill_v;
    logic [TAG_W-1:0]  tag_v [NCLI];
    logic [21:0]       off_v [NCLI];

    assign cs_v = {snd_cs, main_cs, obj_cs, scr_cs, char_cs};
    assign ok_v = {snd_ok, main_ok, obj_ok, scr_ok, char_ok};
    assign pend = cs_v & ~ok_v;

    assign tag_v[CLI_CHAR] = TAG_W'(char_addr[12:1]);
    assign tag_v[CLI_SCR]  = TAG_W'(scr_addr[14:1]);
    assign tag_v[CLI_OBJ]  = TAG_W'(obj_addr[14:1]);
    assign tag_v[CLI_MAIN] = main_addr[16:1];
    assign tag_v[CLI_SND]  = TAG_W'(snd_addr[14:1]);

    assign off_v[CLI_CHAR] = CHAR_OFF;
    assign off_v[CLI_SCR]  = SCR_OFF;
    assign off_v[CLI_OBJ]  = OBJ_OFF;
    assign off_v[CLI_MAIN] = MAIN_OFF;
    assign off_v[CLI_SND]  = SND_OFF;

    // Pick the first pending client at or after ptr; scanning downward lets the nearest one win
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int k = NCLI - 1; k >= 0; k--) begin
            if (pend[3'((int'(ptr) + k) % NCLI)]) begin
                found = 1'b1;
                pick  = 3'((int'(ptr) + k) % NCLI);
            end
        end
    end

    // Next state plus the grant and fill strobes; data_rdy only counts while waiting for data
    always_comb begin
        st_nxt   = st;
        grant    = 1'b0;
        fill_any = 1'b0;
        case (st)
            IDLE: begin
                if (found && !downloading) begin
                    grant  = 1'b1;
                    st_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) st_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    fill_any = 1'b1;
                    st_nxt   = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // State register and request datapath; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            ptr        <= 3'd0;
            gnt        <= 3'd0;
            lat_addr   <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= 22'd0;
        end else begin
            st <= st_nxt;
            if (grant) begin
                gnt        <= pick;
                lat_addr   <= tag_v[pick];
                sdram_addr <= off_v[pick] + 22'(tag_v[pick]);
                sdram_req  <= 1'b1;
                ptr        <= next_cli(pick);
            end else if (st == WAIT_ACK && sdram_ack) begin
                sdram_req <= 1'b0;
            end
        end
    end

    assign fill_v = fill_any ? (NCLI'(1) << gnt) : '0;

    jt1942_rom_line #(.AW(13)) u_char (
        .clk(clk), .rst(rst), .addr(char_addr), .cs(char_cs), .inval(downloading),
        .fill(fill_v[CLI_CHAR]), .fill_tag(lat_addr[11:0]), .fill_word(sdram_dout),
        .ok(char_ok), .data(char_data)
    );

    jt1942_rom_line #(.AW(15)) u_scr (
        .clk(clk), .rst(rst), .addr(scr_addr), .cs(scr_cs), .inval(downloading),
        .fill(fill_v[CLI_SCR]), .fill_tag(lat_addr[13:0]), .fill_word(sdram_dout),
        .ok(scr_ok), .data(scr_data)
    );

    jt1942_rom_line #(.AW(15)) u_obj (
        .clk(clk), .rst(rst), .addr(obj_addr), .cs(obj_cs), .inval(downloading),
        .fill(fill_v[CLI_OBJ]), .fill_tag(lat_addr[13:0]), .fill_word(sdram_dout),
        .ok(obj_ok), .data(obj_data)
    );

    jt1942_rom_line #(.AW(17)) u_main (
        .clk(clk), .rst(rst), .addr(main_addr), .cs(main_cs), .inval(downloading),
        .fill(fill_v[CLI_MAIN]), .fill_tag(lat_addr[15:0]), .fill_word(sdram_dout),
        .ok(main_ok), .data(main_data)
    );

    jt1942_rom_line #(.AW(15)) u_snd (
        .clk(clk), .rst(rst), .addr(snd_addr), .cs(snd_cs), .inval(downloading),
        .fill(fill_v[CLI_SND]), .fill_tag(lat_addr[13:0]), .fill_word(sdram_dout),
        .ok(snd_ok), .data(snd_data)
    );
endmodule

// File: tb/tb_jt1942_rom_sched.sv
// Bench for jt1942_rom_sched: plays the SDRAM controller and tracks caches at transaction level.
// Latency: n/a.
// Backpressure: ack/data delays randomised per transaction.
module tb_jt1942_rom_sched;
    localparam logic [21:0] OFF_CHAR = 22'h3FFFFF;
    localparam logic [21:0] OFF_SCR  = 22'h100000;
    localparam logic [21:0] OFF_OBJ  = 22'h200000;
    localparam logic [21:0] OFF_MAIN = 22'h000000;
    localparam logic [21:0] OFF_SND  = 22'h2ABCD0;

    logic        clk = 1'b0;
    logic        rst, downloading;
    logic [12:0] char_addr;
    logic [14:0] scr_addr, obj_addr, snd_addr;
    logic [16:0] main_addr;
    logic        char_cs, scr_cs, obj_cs, main_cs, snd_cs;
    logic        char_ok, scr_ok, obj_ok, main_ok, snd_ok;
    logic [7:0]  char_data, scr_data, obj_data, main_data, snd_data;
    logic        sdram_req, sdram_ack, data_rdy;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_dout;

    always #5 clk = ~clk;

    // Bench-side client view, indexed char, scr, obj, main, snd
    logic        cs_a [5];
    logic [16:0] ad_a [5];
    logic        ok_a [5];
    logic [7:0]  dat_a [5];

    assign char_cs = cs_a[0]; assign char_addr = ad_a[0][12:0];
    assign scr_cs  = cs_a[1]; assign scr_addr  = ad_a[1][14:0];
    assign obj_cs  = cs_a[2]; assign obj_addr  = ad_a[2][14:0];
    assign main_cs = cs_a[3]; assign main_addr = ad_a[3];
    assign snd_cs  = cs_a[4]; assign snd_addr  = ad_a[4][14:0];
    assign ok_a[0] = char_ok; assign dat_a[0] = char_data;
    assign ok_a[1] = scr_ok;  assign dat_a[1] = scr_data;
    assign ok_a[2] = obj_ok;  assign dat_a[2] = obj_data;
    assign ok_a[3] = main_ok; assign dat_a[3] = main_data;
    assign ok_a[4] = snd_ok;  assign dat_a[4] = snd_data;

    jt1942_rom_sched #(
        .CHAR_OFF(OFF_CHAR), .SCR_OFF(OFF_SCR), .OBJ_OFF(OFF_OBJ),
        .MAIN_OFF(OFF_MAIN), .SND_OFF(OFF_SND)
    ) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .char_addr(char_addr), .scr_addr(scr_addr), .obj_addr(obj_addr),
        .main_addr(main_addr), .snd_addr(snd_addr),
        .char_cs(char_cs), .scr_cs(scr_cs), .obj_cs(obj_cs), .main_cs(main_cs), .snd_cs(snd_cs),
        .char_ok(char_ok), .scr_ok(scr_ok), .obj_ok(obj_ok), .main_ok(main_ok), .snd_ok(snd_ok),
        .char_data(char_data), .scr_data(scr_data), .obj_data(obj_data),
        .main_data(main_data), .snd_data(snd_data),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .sdram_dout(sdram_dout)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: what each line should hold, and the round-robin pointer
    bit          m_valid [5];
    logic [15:0] m_tag [5];
    logic [15:0] m_word [5];
    int          m_ptr;

    function automatic int aw(input int i);
        if (i == 0) return 13;
        if (i == 3) return 17;
        return 15;
    endfunction

    function automatic logic [21:0] off_of(input int i);
        case (i)
            0: return OFF_CHAR;
            1: return OFF_SCR;
            2: return OFF_OBJ;
            3: return OFF_MAIN;
            default: return OFF_SND;
        endcase
    endfunction

    function automatic bit m_hit(input int i);
        return cs_a[i] && m_valid[i] && (m_tag[i] == 16'(ad_a[i] >> 1));
    endfunction

    function automatic logic [7:0] m_byte(input int i);
        logic [15:0] w;
        w = m_word[i];
        return ad_a[i][0] ? w[15:8] : w[7:0];
    endfunction

    // Next client the scheduler should grant, or -1 when nobody is missing
    function automatic int m_next();
        for (int k = 0; k < 5; k++) begin
            int i;
            i = (m_ptr + k) % 5;
            if (cs_a[i] && !m_hit(i)) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; downloading = 1'b0;
        sdram_ack = 1'b0; data_rdy = 1'b0; sdram_dout = 16'h0;
        for (int i = 0; i < 5; i++) begin
            cs_a[i] = 1'b0; ad_a[i] = 17'h0;
            m_valid[i] = 1'b0; m_tag[i] = 16'h0; m_word[i] = 16'h0;
        end
        m_ptr = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Act as the controller for one transaction expected for client c
    task automatic service(input int c, input logic [15:0] word, input int ack_dly,
                           input int dat_dly, input bit glitch, input bit dl);
        int          waited;
        logic [15:0] t;
        logic [21:0] ea;
        waited = 0;
        while (sdram_req !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        nvec++;
        if (sdram_req !== 1'b1) begin
            nerr++;
            $display("FAIL req_timeout client %0d: sdram_req=%b required 1", c, sdram_req);
            return;
        end
        t  = 16'(ad_a[c] >> 1);
        ea = off_of(c) + 22'(t);
        nvec++;
        if (sdram_addr !== ea) begin
            nerr++;
            $display("FAIL grant_addr client %0d: sdram_addr=%h required %h", c, sdram_addr, ea);
        end
        repeat (ack_dly) tick();
        sdram_ack = 1'b1;
        if (glitch) begin
            data_rdy = 1'b1;
            sdram_dout = ~word;
        end
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        nvec++;
        if (sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL req_fall client %0d: sdram_req=%b required 0", c, sdram_req);
        end
        repeat (dat_dly) tick();
        data_rdy = 1'b1;
        sdram_dout = word;
        if (dl) downloading = 1'b1;
        tick();
        data_rdy = 1'b0;
        downloading = 1'b0;
        m_tag[c] = t;
        m_word[c] = word;
        m_valid[c] = !dl;
        m_ptr = (c + 1) % 5;
        nvec++;
        if (ok_a[c] !== m_hit(c) || dat_a[c] !== m_byte(c)) begin
            nerr++;
            $display("FAIL fill_result client %0d: ok=%b data=%h required ok=%b data=%h",
                     c, ok_a[c], dat_a[c], m_hit(c), m_byte(c));
        end
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin
            nerr++;
            $display("FAIL reset_req: req=%b addr=%h required 0/000000", sdram_req, sdram_addr);
        end
        for (int i = 0; i < 5; i++) begin
            cs_a[i] = 1'b1;
            ad_a[i] = 17'($urandom) & ((17'h1 << aw(i)) - 17'h1);
        end
        #1;
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (ok_a[i] !== 1'b0 || dat_a[i] !== 8'h0) begin
                nerr++;
                $display("FAIL reset_client %0d: ok=%b data=%h required 0/00", i, ok_a[i], dat_a[i]);
            end
        end
        for (int i = 0; i < 5; i++) cs_a[i] = 1'b0;
        tick();
    endtask

    task automatic test_main_miss_hit();
        do_reset();
        cs_a[3] = 1'b1;
        ad_a[3] = 17'h00003;
        tick();
        nvec++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h1) begin
            nerr++;
            $display("FAIL main_req: req=%b addr=%h required 1/000001", sdram_req, sdram_addr);
        end
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        nvec++;
        if (sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL main_req_fall: req=%b required 0", sdram_req);
        end
        tick();
        tick();
        data_rdy = 1'b1;
        sdram_dout = 16'hA55A;
        #1;
        nvec++;
        if (main_ok !== 1'b0) begin
            nerr++;
            $display("FAIL main_ok_early: ok=%b required 0", main_ok);
        end
        tick();
        data_rdy = 1'b0;
        nvec++;
        if (main_ok !== 1'b1 || main_data !== 8'hA5) begin
            nerr++;
            $display("FAIL main_fill: ok=%b data=%h required 1/a5", main_ok, main_data);
        end
        ad_a[3] = 17'h00002;
        #1;
        nvec++;
        if (main_ok !== 1'b1 || main_data !== 8'h5A || sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL main_hit: ok=%b data=%h req=%b required 1/5a/0", main_ok, main_data, sdram_req);
        end
        tick();
        nvec++;
        if (sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL main_hit_noreq: req=%b required 0", sdram_req);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cs_a[i] = 1'b1;
            ad_a[i] = 17'h10 + 17'(i * 18);
        end
        for (int i = 0; i < 5; i++) service(i, 16'($urandom), 1, 2, 1'b0, 1'b0);
        ad_a[0] = 17'h12;
        ad_a[3] = 17'h48;
        service(0, 16'($urandom), 0, 1, 1'b1, 1'b0);
        service(3, 16'($urandom), 2, 0, 1'b0, 1'b0);
        tick();
        nvec++;
        if (sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL rr_idle: req=%b required 0", sdram_req);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cs_a[0] = 1'b1;
        ad_a[0] = 17'h0004;
        tick();
        nvec++;
        if (sdram_addr !== 22'h000001) begin
            nerr++;
            $display("FAIL wrap_addr: sdram_addr=%h required 000001", sdram_addr);
        end
        service(0, 16'h1234, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_drop_cs();
        do_reset();
        cs_a[4] = 1'b1;
        ad_a[4] = 17'h00AB;
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        cs_a[4] = 1'b0;
        tick();
        data_rdy = 1'b1;
        sdram_dout = 16'hC37E;
        tick();
        data_rdy = 1'b0;
        tick();
        nvec++;
        if (sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL drop_noreq: req=%b required 0", sdram_req);
        end
        cs_a[4] = 1'b1;
        #1;
        nvec++;
        if (snd_ok !== 1'b1 || snd_data !== 8'hC3) begin
            nerr++;
            $display("FAIL drop_rehit: ok=%b data=%h required 1/c3", snd_ok, snd_data);
        end
        tick();
        nvec++;
        if (sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL drop_rehit_noreq: req=%b required 0", sdram_req);
        end
    endtask

    task automatic test_download();
        do_reset();
        cs_a[0] = 1'b1; ad_a[0] = 17'h0021;
        cs_a[1] = 1'b1; ad_a[1] = 17'h0100;
        service(0, 16'($urandom), 0, 0, 1'b0, 1'b0);
        service(1, 16'($urandom), 1, 1, 1'b0, 1'b0);
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (ok_a[i] !== 1'b0) begin
                nerr++;
                $display("FAIL dl_ok client %0d: ok=%b required 0", i, ok_a[i]);
            end
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            nvec++;
            if (sdram_req !== 1'b0) begin
                nerr++;
                $display("FAIL dl_noreq cycle %0d: req=%b required 0", n, sdram_req);
            end
        end
        downloading = 1'b0;
        #1;
        nvec++;
        if (char_ok !== 1'b0) begin
            nerr++;
            $display("FAIL dl_remiss: ok=%b required 0", char_ok);
        end
        service(m_next(), 16'($urandom), 1, 1, 1'b0, 1'b1);
        while (m_next() >= 0) service(m_next(), 16'($urandom), 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cs_a[1] = 1'b1;
        ad_a[1] = 17'h0031;
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        rst = 1'b1;
        cs_a[1] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        data_rdy = 1'b1;
        sdram_dout = 16'hBEEF;
        tick();
        data_rdy = 1'b0;
        nvec++;
        if (sdram_req !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_req: req=%b required 0", sdram_req);
        end
        for (int i = 0; i < 5; i++) cs_a[i] = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (ok_a[i] !== 1'b0 || dat_a[i] !== 8'h00) begin
                nerr++;
                $display("FAIL rstmid_client %0d: ok=%b data=%h required 0/00", i, ok_a[i], dat_a[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 60; r++) begin
            int guard;
            for (int i = 0; i < 5; i++) begin
                cs_a[i] = 1'($urandom);
                ad_a[i] = 17'($urandom_range(0, 7));
            end
            #1;
            for (int i = 0; i < 5; i++) begin
                nvec++;
                if (ok_a[i] !== m_hit(i) || dat_a[i] !== m_byte(i)) begin
                    nerr++;
                    $display("FAIL rand_view round %0d client %0d: ok=%b data=%h required %b/%h",
                             r, i, ok_a[i], dat_a[i], m_hit(i), m_byte(i));
                end
            end
            guard = 0;
            while (m_next() >= 0 && guard < 8) begin
                service(m_next(), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                        1'($urandom), 1'b0);
                guard++;
            end
            tick();
            nvec++;
            if (sdram_req !== 1'b0) begin
                nerr++;
                $display("FAIL rand_idle round %0d: req=%b required 0", r, sdram_req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_main_miss_hit();
        test_round_robin();
        test_wrap();
        test_drop_cs();
        test_download();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
